// File: rtl/cia_timer_bank.sv
// Bank of N_CH cascadable WIDTH-bit down-counters with byte-wide latch/control access.
// All counting is qualified by the phi2_dn tick strobe; underflows ripple to the next channel in the same tick.
module cia_timer_bank #(
    parameter int N_CH  = 2,
    parameter int WIDTH = 16,
    localparam int NB   = WIDTH / 8,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int RS_W = $clog2(NB + 1)
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic                    phi2_dn,
    input  logic                    we,
    input  logic [CH_W-1:0]         ch_sel,
    input  logic [RS_W-1:0]         reg_sel,
    input  logic [7:0]              data,
    input  logic                    cnt_up,
    input  logic                    cnt,
    output logic [N_CH*WIDTH-1:0]   count,
    output logic [N_CH*8-1:0]       ctrl,
    output logic [N_CH-1:0]         t_int,
    output logic [N_CH-1:0]         pb,
    output logic [N_CH-1:0]         pb_oe
);

    // Stored control bits: LOAD (bit 4) is a strobe and bit 7 is reserved.
    localparam logic [7:0] CTRL_MASK = 8'h6F;

    logic [WIDTH-1:0] count_q [N_CH];
    logic [WIDTH-1:0] count_d [N_CH];
    logic [WIDTH-1:0] latch_q [N_CH];
    logic [WIDTH-1:0] latch_d [N_CH];
    logic [7:0]       ctrl_q  [N_CH];
    logic [7:0]       ctrl_d  [N_CH];

    logic [N_CH-1:0] pend_q, pend_d;
    logic [N_CH-1:0] tog_q, tog_d;
    logic [N_CH-1:0] pulse_q, pulse_d;
    logic [N_CH-1:0] t_int_q, t_int_d;
    logic [N_CH-1:0] pb_q, pb_d;

    logic [N_CH-1:0] evt;
    logic [N_CH-1:0] uf;
    logic            prev_uf;
    logic            src;
    logic            wr_ch;

    always_comb begin
        evt     = '0;
        uf      = '0;
        prev_uf = 1'b0;
        src     = 1'b0;
        wr_ch   = 1'b0;
        count_d = count_q;
        latch_d = latch_q;
        ctrl_d  = ctrl_q;
        pend_d  = pend_q;
        tog_d   = tog_q;
        pulse_d = pulse_q;
        t_int_d = '0;
        pb_d    = '0;
        for (int i = 0; i < N_CH; i++) begin
            // prev_uf carries channel i-1's underflow of this tick; it is 0 for channel 0.
            case (ctrl_q[i][6:5])
                2'b00:   src = 1'b1;
                2'b01:   src = cnt_up;
                2'b10:   src = prev_uf;
                default: src = prev_uf & cnt;
            endcase
            evt[i]  = phi2_dn & ctrl_q[i][0] & src;
            uf[i]   = evt[i] & ~pend_q[i] & (count_q[i] == '0);
            prev_uf = uf[i];
            t_int_d[i] = uf[i];

            if (phi2_dn) begin
                pulse_d[i] = uf[i];
                if (pend_q[i]) begin
                    count_d[i] = latch_q[i];
                    pend_d[i]  = 1'b0;
                end else if (uf[i]) begin
                    count_d[i] = latch_q[i];
                    tog_d[i]   = ~tog_q[i];
                    if (ctrl_q[i][3]) begin
                        ctrl_d[i][0] = 1'b0;
                    end
                end else if (evt[i]) begin
                    count_d[i] = count_q[i] - WIDTH'(1);
                end
            end

            // Register writes land after the tick so each written field overrides the tick result.
            wr_ch = we && (ch_sel == CH_W'(i));
            if (wr_ch) begin
                if (reg_sel == RS_W'(NB)) begin
                    ctrl_d[i] = data & CTRL_MASK;
                    if (data[4]) begin
                        pend_d[i] = 1'b1;
                    end
                    if (!ctrl_q[i][0] && data[0]) begin
                        tog_d[i] = 1'b1;
                    end
                end else begin
                    for (int b = 0; b < NB; b++) begin
                        if (reg_sel == RS_W'(b)) begin
                            latch_d[i][b*8 +: 8] = data;
                            if (b == NB - 1 && !ctrl_q[i][0]) begin
                                count_d[i] = latch_d[i];
                            end
                        end
                    end
                end
            end

            pb_d[i] = ctrl_d[i][1] & (ctrl_d[i][2] ? tog_d[i] : pulse_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            count_q <= '{default: '1};
            latch_q <= '{default: '1};
            ctrl_q  <= '{default: '0};
            pend_q  <= '0;
            tog_q   <= '0;
            pulse_q <= '0;
            t_int_q <= '0;
            pb_q    <= '0;
        end else begin
            count_q <= count_d;
            latch_q <= latch_d;
            ctrl_q  <= ctrl_d;
            pend_q  <= pend_d;
            tog_q   <= tog_d;
            pulse_q <= pulse_d;
            t_int_q <= t_int_d;
            pb_q    <= pb_d;
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_out
        assign count[gi*WIDTH +: WIDTH] = count_q[gi];
        assign ctrl[gi*8 +: 8]          = ctrl_q[gi];
        assign t_int[gi]                = t_int_q[gi];
        assign pb[gi]                   = pb_q[gi];
        assign pb_oe[gi]                = ctrl_q[gi][1];
    end

endmodule

// File: tb/tb_cia_timer_bank.sv
// Directed bench for cia_timer_bank (2 channels x 16 bits) with hand-computed expectations.
module tb_cia_timer_bank;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        phi2_dn = 1'b0;
    logic        we = 1'b0;
    logic [0:0]  ch_sel = '0;
    logic [1:0]  reg_sel = '0;
    logic [7:0]  data = '0;
    logic        cnt_up = 1'b0;
    logic        cnt = 1'b0;
    logic [31:0] count;
    logic [15:0] ctrl;
    logic [1:0]  t_int;
    logic [1:0]  pb;
    logic [1:0]  pb_oe;

    int n_checks = 0;
    int n_fail   = 0;

    cia_timer_bank #(.N_CH(2), .WIDTH(16)) dut (
        .clk(clk), .res(res), .phi2_dn(phi2_dn), .we(we), .ch_sel(ch_sel),
        .reg_sel(reg_sel), .data(data), .cnt_up(cnt_up), .cnt(cnt),
        .count(count), .ctrl(ctrl), .t_int(t_int), .pb(pb), .pb_oe(pb_oe)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int rs, input logic [7:0] d);
        we = 1'b1; ch_sel = 1'(ch); reg_sel = 2'(rs); data = d;
        cyc();
        we = 1'b0;
        $display("write ch%0d reg%0d=%h -> ch0=%h ch1=%h ctrl=%h", ch, rs, d, count[15:0], count[31:16], ctrl);
    endtask

    task automatic tick();
        phi2_dn = 1'b1;
        cyc();
        phi2_dn = 1'b0;
        $display("tick -> ch0=%h ch1=%h t_int=%b pb=%b", count[15:0], count[31:16], t_int, pb);
    endtask

    task automatic tick_wr(input int ch, input int rs, input logic [7:0] d);
        phi2_dn = 1'b1; we = 1'b1; ch_sel = 1'(ch); reg_sel = 2'(rs); data = d;
        cyc();
        phi2_dn = 1'b0; we = 1'b0;
        $display("tick+write ch%0d reg%0d=%h -> ch0=%h t_int=%b", ch, rs, d, count[15:0], t_int);
    endtask

    task automatic do_reset();
        res = 1'b1;
        cyc(); cyc();
        res = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (count !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_count got=%h exp=ffffffff", count); end
        n_checks++;
        if (ctrl !== 16'h0000) begin n_fail++; $display("FAIL reset_ctrl got=%h exp=0000", ctrl); end
        n_checks++;
        if ({t_int, pb, pb_oe} !== 6'b0) begin n_fail++; $display("FAIL reset_outs got=%b exp=000000", {t_int, pb, pb_oe}); end
    endtask

    task automatic test_continuous();
        logic [15:0] exp_cnt [10] = '{16'd2, 16'd1, 16'd0, 16'd3, 16'd2, 16'd1, 16'd0, 16'd3, 16'd2, 16'd1};
        wr(0, 0, 8'h03);
        wr(0, 1, 8'h00);
        n_checks++;
        if (count[15:0] !== 16'h0003) begin n_fail++; $display("FAIL cont_stopped_load got=%h exp=0003", count[15:0]); end
        wr(0, 2, 8'h01);
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_checks++;
            if (count[15:0] !== exp_cnt[k-1]) begin
                n_fail++; $display("FAIL cont_count tick%0d got=%h exp=%h", k, count[15:0], exp_cnt[k-1]);
            end
            n_checks++;
            if (t_int[0] !== (k == 4 || k == 8)) begin
                n_fail++; $display("FAIL cont_tint tick%0d got=%b exp=%b", k, t_int[0], (k == 4 || k == 8));
            end
            cyc();
            n_checks++;
            if (t_int !== 2'b00) begin n_fail++; $display("FAIL cont_tint_width tick%0d got=%b exp=00", k, t_int); end
        end
        n_checks++;
        if ({count[31:16], ctrl[15:8]} !== 24'hFFFF00) begin
            n_fail++; $display("FAIL cont_ch1_idle got=%h exp=ffff00", {count[31:16], ctrl[15:8]});
        end
    endtask

    task automatic test_one_shot();
        wr(0, 2, 8'h00);
        wr(0, 0, 8'h02);
        wr(0, 1, 8'h00);
        wr(0, 2, 8'h09);
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_checks++;
            if (t_int[0] !== (k == 3)) begin n_fail++; $display("FAIL oneshot_tint tick%0d got=%b exp=%b", k, t_int[0], (k == 3)); end
        end
        n_checks++;
        if (ctrl[7:0] !== 8'h08) begin n_fail++; $display("FAIL oneshot_ctrl got=%h exp=08", ctrl[7:0]); end
        n_checks++;
        if (count[15:0] !== 16'h0002) begin n_fail++; $display("FAIL oneshot_count got=%h exp=0002", count[15:0]); end
    endtask

    task automatic test_cascade();
        logic [15:0] exp_c1 [6] = '{16'd2, 16'd1, 16'd1, 16'd0, 16'd0, 16'd2};
        logic [1:0]  exp_ti [6] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b11};
        do_reset();
        wr(0, 0, 8'h01); wr(0, 1, 8'h00);
        wr(1, 0, 8'h02); wr(1, 1, 8'h00);
        wr(1, 2, 8'h41);
        wr(0, 2, 8'h01);
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_checks++;
            if (count[31:16] !== exp_c1[k-1]) begin n_fail++; $display("FAIL casc_ch1 tick%0d got=%h exp=%h", k, count[31:16], exp_c1[k-1]); end
            n_checks++;
            if (t_int !== exp_ti[k-1]) begin n_fail++; $display("FAIL casc_tint tick%0d got=%b exp=%b", k, t_int, exp_ti[k-1]); end
        end
        wr(1, 2, 8'h61);
        n_checks++;
        if (ctrl[15:8] !== 8'h61) begin n_fail++; $display("FAIL casc_ctrl got=%h exp=61", ctrl[15:8]); end
        cnt = 1'b0;
        tick(); tick();
        n_checks++;
        if (count[31:16] !== 16'd2) begin n_fail++; $display("FAIL gated_frozen got=%h exp=0002", count[31:16]); end
        cnt = 1'b1;
        tick(); tick();
        cnt = 1'b0;
        n_checks++;
        if (count[31:16] !== 16'd1) begin n_fail++; $display("FAIL gated_open got=%h exp=0001", count[31:16]); end
        wr(1, 2, 8'h21);
        tick();
        n_checks++;
        if (count[31:16] !== 16'd1) begin n_fail++; $display("FAIL cntup_idle got=%h exp=0001", count[31:16]); end
        cnt_up = 1'b1;
        tick();
        cnt_up = 1'b0;
        n_checks++;
        if (count[31:16] !== 16'd0) begin n_fail++; $display("FAIL cntup_edge got=%h exp=0000", count[31:16]); end
    endtask

    task automatic test_pb();
        logic exp_tog [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic exp_pul [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        wr(0, 0, 8'h01); wr(0, 1, 8'h00);
        wr(0, 2, 8'h07);
        n_checks++;
        if ({pb[0], pb_oe[0]} !== 2'b11) begin n_fail++; $display("FAIL pb_start got=%b exp=11", {pb[0], pb_oe[0]}); end
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_checks++;
            if (pb[0] !== exp_tog[k-1]) begin n_fail++; $display("FAIL pb_toggle tick%0d got=%b exp=%b", k, pb[0], exp_tog[k-1]); end
        end
        wr(0, 2, 8'h03);
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_checks++;
            if (pb[0] !== exp_pul[k-1]) begin n_fail++; $display("FAIL pb_pulse tick%0d got=%b exp=%b", k, pb[0], exp_pul[k-1]); end
            if (k == 2) begin
                cyc();
                n_checks++;
                if (pb[0] !== 1'b1) begin n_fail++; $display("FAIL pb_pulse_hold got=%b exp=1", pb[0]); end
            end
        end
        wr(0, 2, 8'h01);
        n_checks++;
        if ({pb[0], pb_oe[0]} !== 2'b00) begin n_fail++; $display("FAIL pb_off got=%b exp=00", {pb[0], pb_oe[0]}); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        wr(0, 0, 8'h02); wr(0, 1, 8'h00);
        wr(0, 2, 8'h01);
        tick(); tick();
        tick_wr(0, 1, 8'h01);
        n_checks++;
        if ({count[15:0], t_int[0]} !== {16'h0002, 1'b1}) begin
            n_fail++; $display("FAIL b2b_reload got=%h/%b exp=0002/1", count[15:0], t_int[0]);
        end
        wr(0, 2, 8'h11);
        n_checks++;
        if ({ctrl[7:0], count[15:0]} !== 24'h010002) begin
            n_fail++; $display("FAIL b2b_load_rd got=%h exp=010002", {ctrl[7:0], count[15:0]});
        end
        tick();
        n_checks++;
        if ({count[15:0], t_int[0]} !== {16'h0102, 1'b0}) begin
            n_fail++; $display("FAIL b2b_pending got=%h/%b exp=0102/0", count[15:0], t_int[0]);
        end
        tick();
        tick_wr(0, 2, 8'h11);
        n_checks++;
        if (count[15:0] !== 16'h0100) begin n_fail++; $display("FAIL b2b_load_tick got=%h exp=0100", count[15:0]); end
        tick();
        n_checks++;
        if ({count[15:0], t_int[0]} !== {16'h0102, 1'b0}) begin
            n_fail++; $display("FAIL b2b_load_next got=%h/%b exp=0102/0", count[15:0], t_int[0]);
        end
        wr(0, 2, 8'h00);
        wr(0, 1, 8'h05);
        n_checks++;
        if (count[15:0] !== 16'h0502) begin n_fail++; $display("FAIL b2b_hi_load got=%h exp=0502", count[15:0]); end
        wr(0, 2, 8'h07);
        tick();
        n_checks++;
        if ({count[15:0], pb[0]} !== {16'h0501, 1'b1}) begin
            n_fail++; $display("FAIL b2b_prereset got=%h/%b exp=0501/1", count[15:0], pb[0]);
        end
        res = 1'b1; phi2_dn = 1'b1; we = 1'b1; ch_sel = 1'b0; reg_sel = 2'd2; data = 8'h13;
        cyc();
        res = 1'b0; phi2_dn = 1'b0; we = 1'b0;
        $display("reset+tick+write -> count=%h ctrl=%h", count, ctrl);
        n_checks++;
        if ({count, ctrl} !== 48'hFFFF_FFFF_0000) begin
            n_fail++; $display("FAIL midreset_regs got=%h exp=ffffffff0000", {count, ctrl});
        end
        n_checks++;
        if ({t_int, pb, pb_oe} !== 6'b0) begin n_fail++; $display("FAIL midreset_outs got=%b exp=000000", {t_int, pb, pb_oe}); end
        tick();
        n_checks++;
        if (count[15:0] !== 16'hFFFF) begin n_fail++; $display("FAIL midreset_noload got=%h exp=ffff", count[15:0]); end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_one_shot();
        test_cascade();
        test_pb();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
